// File: rtl/wb_master_ctrl.sv
// Wishbone classic master for the core data port: one transaction at a time,
// with byte lanes, err termination and an optional access timeout.
module wb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DATA_W / 8,
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_write_data,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_data_out,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_d;
  logic             rd_r, wr_r;
  logic             rd_start, wr_start;
  logic             launch, finish_ok, finish_err;
  logic [CNT_W-1:0] cnt;

  assign rd_start = d_read_en & ~rd_r;
  assign wr_start = d_write_en & ~wr_r;
  assign busy_o   = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    launch     = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (wr_start || rd_start) begin
          launch  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // err beats ack, and either beats a timeout expiring on the same edge
        if (wbm_err_i)                            finish_err = 1'b1;
        else if (wbm_ack_i)                       finish_ok  = 1'b1;
        else if (TIMEOUT != 0 && cnt == CNT_LAST) finish_err = 1'b1;
        if (finish_ok || finish_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      cnt        <= '0;
      d_data_out <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      wbm_dat_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_sel_o  <= '0;
      wbm_we_o   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
    end else begin
      rd_r   <= d_read_en;
      wr_r   <= d_write_en;
      done_o <= finish_ok | finish_err;
      err_o  <= finish_err;

      if (state == WAIT && !(finish_ok || finish_err)) cnt <= cnt + CNT_W'(1);
      else                                             cnt <= '0;

      // a simultaneous read edge is dropped: we follows the write edge
      if (launch) begin
        wbm_adr_o <= d_addr;
        wbm_sel_o <= d_sel;
        wbm_we_o  <= wr_start;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        if (wr_start) wbm_dat_o <= d_write_data;
      end

      if (finish_ok || finish_err) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
      end

      if (finish_ok && !wbm_we_o) d_data_out <= wbm_dat_i;
    end
  end

endmodule
